// File: rtl/battle_pkg.sv
// Shared types and defaults for the battle turn sequencer slice.
package battle_pkg;

  localparam int DEF_NUM_MON = 3;
  localparam int DEF_HP_W    = 8;
  localparam int DEF_IDX_W   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ1,
    S_MSG1,
    S_REQ2,
    S_MSG2,
    S_FAINT_CHK,
    S_OVER
  } seq_state_t;

  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_PLAYER = 3'd1;
  localparam logic [2:0] PH_ENEMY  = 3'd2;
  localparam logic [2:0] PH_WIN    = 3'd3;
  localparam logic [2:0] PH_LOSE   = 3'd4;

endpackage

// File: rtl/next_alive.sv
// Finds the next mon with HP > 0, searching upward from cur+1 and wrapping.
module next_alive
  import battle_pkg::*;
#(
  parameter int NUM_MON = DEF_NUM_MON,
  parameter int HP_W    = DEF_HP_W,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic [NUM_MON*HP_W-1:0] hp,
  input  logic [IDX_W-1:0]        cur,
  output logic [IDX_W-1:0]        next_idx,
  output logic                    any_alive
);

  // Walk offsets from the far end down so the nearest live mon wins.
  always_comb begin
    next_idx  = cur;
    any_alive = 1'b0;
    for (int k = NUM_MON; k >= 1; k--) begin
      if (hp[((int'(cur) + k) % NUM_MON)*HP_W +: HP_W] != '0) begin
        next_idx  = IDX_W'((int'(cur) + k) % NUM_MON);
        any_alive = 1'b1;
      end
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Sequences one battle turn: speed ordering, damage requests, HP, fainting, win/lose.
module turn_sequencer
  import battle_pkg::*;
#(
  parameter int NUM_MON = DEF_NUM_MON,
  parameter int HP_W    = DEF_HP_W,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    load,
  input  logic [NUM_MON*HP_W-1:0] player_maxhp,
  input  logic [NUM_MON*HP_W-1:0] enemy_maxhp,
  input  logic                    start_turn,
  input  logic [HP_W-1:0]         player_speed,
  input  logic [HP_W-1:0]         enemy_speed,
  output logic                    calc_req,
  output logic                    calc_is_player,
  input  logic                    calc_ack,
  input  logic [HP_W-1:0]         calc_damage,
  input  logic                    advance,
  output logic [NUM_MON*HP_W-1:0] player_hp,
  output logic [NUM_MON*HP_W-1:0] enemy_hp,
  output logic [IDX_W-1:0]        cur_mon,
  output logic [IDX_W-1:0]        opp_mon,
  output logic [2:0]              phase,
  output logic                    busy,
  output logic                    turn_done,
  output logic                    battle_over,
  output logic                    result
);

  seq_state_t state, state_n;

  logic [NUM_MON*HP_W-1:0] php_q, php_n, ehp_q, ehp_n;
  logic [IDX_W-1:0]        cur_q, cur_n, opp_q, opp_n;
  logic                    first_q, first_n;
  logic                    req_q, req_n;
  logic                    isp_q, isp_n;
  logic                    res_q, res_n;

  logic [IDX_W-1:0] p_next, e_next;
  logic             p_any, e_any;

  logic             attacker_is_player;
  logic [HP_W-1:0]  def_hp, def_hp_after;

  next_alive #(.NUM_MON(NUM_MON), .HP_W(HP_W), .IDX_W(IDX_W)) u_player_alive (
    .hp        (php_q),
    .cur       (cur_q),
    .next_idx  (p_next),
    .any_alive (p_any)
  );

  next_alive #(.NUM_MON(NUM_MON), .HP_W(HP_W), .IDX_W(IDX_W)) u_enemy_alive (
    .hp        (ehp_q),
    .cur       (opp_q),
    .next_idx  (e_next),
    .any_alive (e_any)
  );

  // Second attack swaps roles; defender HP after saturating damage.
  always_comb begin
    attacker_is_player = (state == S_REQ2 || state == S_MSG2) ? ~first_q : first_q;
    def_hp = attacker_is_player ? ehp_q[opp_q*HP_W +: HP_W] : php_q[cur_q*HP_W +: HP_W];
    def_hp_after = (calc_damage >= def_hp) ? '0 : def_hp - calc_damage;
  end

  // Next-state and next-register values for the turn FSM.
  always_comb begin
    state_n = state;
    php_n   = php_q;
    ehp_n   = ehp_q;
    cur_n   = cur_q;
    opp_n   = opp_q;
    first_n = first_q;
    req_n   = req_q;
    isp_n   = isp_q;
    res_n   = res_q;
    if (load) begin
      state_n = S_IDLE;
      php_n   = player_maxhp;
      ehp_n   = enemy_maxhp;
      cur_n   = '0;
      opp_n   = '0;
      req_n   = 1'b0;
      isp_n   = 1'b0;
      res_n   = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_turn) begin
            first_n = (player_speed > enemy_speed);
            isp_n   = (player_speed > enemy_speed);
            req_n   = 1'b1;
            state_n = S_REQ1;
          end
        end
        S_REQ1, S_REQ2: begin
          if (calc_ack) begin
            if (attacker_is_player) begin
              ehp_n[opp_q*HP_W +: HP_W] = def_hp_after;
            end else begin
              php_n[cur_q*HP_W +: HP_W] = def_hp_after;
            end
            req_n   = 1'b0;
            state_n = (state == S_REQ1) ? S_MSG1 : S_MSG2;
          end
        end
        S_MSG1: begin
          if (advance) begin
            if (def_hp == '0) begin
              state_n = S_FAINT_CHK;
            end else begin
              req_n   = 1'b1;
              isp_n   = ~first_q;
              state_n = S_REQ2;
            end
          end
        end
        S_MSG2: begin
          if (advance) begin
            state_n = S_FAINT_CHK;
          end
        end
        S_FAINT_CHK: begin
          if (!e_any) begin
            res_n   = 1'b1;
            state_n = S_OVER;
          end else if (!p_any) begin
            res_n   = 1'b0;
            state_n = S_OVER;
          end else begin
            if (ehp_q[opp_q*HP_W +: HP_W] == '0) begin
              opp_n = e_next;
            end
            if (php_q[cur_q*HP_W +: HP_W] == '0) begin
              cur_n = p_next;
            end
            state_n = S_IDLE;
          end
        end
        S_OVER: begin
          state_n = S_OVER;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      php_q   <= '0;
      ehp_q   <= '0;
      cur_q   <= '0;
      opp_q   <= '0;
      first_q <= 1'b0;
      req_q   <= 1'b0;
      isp_q   <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      state   <= state_n;
      php_q   <= php_n;
      ehp_q   <= ehp_n;
      cur_q   <= cur_n;
      opp_q   <= opp_n;
      first_q <= first_n;
      req_q   <= req_n;
      isp_q   <= isp_n;
      res_q   <= res_n;
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy        = (state != S_IDLE) && (state != S_OVER);
    battle_over = (state == S_OVER);
    turn_done   = (state == S_FAINT_CHK) && e_any && p_any;
    case (state)
      S_MSG1, S_MSG2: phase = attacker_is_player ? PH_PLAYER : PH_ENEMY;
      S_OVER:         phase = res_q ? PH_WIN : PH_LOSE;
      default:        phase = PH_IDLE;
    endcase
  end

  assign calc_req       = req_q;
  assign calc_is_player = isp_q;
  assign result         = res_q;
  assign player_hp      = php_q;
  assign enemy_hp       = ehp_q;
  assign cur_mon        = cur_q;
  assign opp_mon        = opp_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed scoreboard bench for turn_sequencer.
module tb_turn_sequencer;

  localparam int NUM_MON = 3;
  localparam int HP_W    = 8;
  localparam int IDX_W   = 2;

  logic                    Clk;
  logic                    Reset;
  logic                    load;
  logic [NUM_MON*HP_W-1:0] player_maxhp;
  logic [NUM_MON*HP_W-1:0] enemy_maxhp;
  logic                    start_turn;
  logic [HP_W-1:0]         player_speed;
  logic [HP_W-1:0]         enemy_speed;
  logic                    calc_req;
  logic                    calc_is_player;
  logic                    calc_ack;
  logic [HP_W-1:0]         calc_damage;
  logic                    advance;
  logic [NUM_MON*HP_W-1:0] player_hp;
  logic [NUM_MON*HP_W-1:0] enemy_hp;
  logic [IDX_W-1:0]        cur_mon;
  logic [IDX_W-1:0]        opp_mon;
  logic [2:0]              phase;
  logic                    busy;
  logic                    turn_done;
  logic                    battle_over;
  logic                    result;

  int checks = 0;
  int errors = 0;

  logic sb[$];
  int expP[3];
  int expE[3];
  int expCur;
  int expOpp;

  turn_sequencer #(.NUM_MON(NUM_MON), .HP_W(HP_W), .IDX_W(IDX_W)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .load           (load),
    .player_maxhp   (player_maxhp),
    .enemy_maxhp    (enemy_maxhp),
    .start_turn     (start_turn),
    .player_speed   (player_speed),
    .enemy_speed    (enemy_speed),
    .calc_req       (calc_req),
    .calc_is_player (calc_is_player),
    .calc_ack       (calc_ack),
    .calc_damage    (calc_damage),
    .advance        (advance),
    .player_hp      (player_hp),
    .enemy_hp       (enemy_hp),
    .cur_mon        (cur_mon),
    .opp_mon        (opp_mon),
    .phase          (phase),
    .busy           (busy),
    .turn_done      (turn_done),
    .battle_over    (battle_over),
    .result         (result)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [23:0] packHp(input int a0, input int a1, input int a2);
    return {8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic int satSub(input int hp, input int dmg);
    return (dmg >= hp) ? 0 : hp - dmg;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic st, input logic adv);
    load       = ld;
    start_turn = st;
    advance    = adv;
    @(negedge Clk);
    load       = 1'b0;
    start_turn = 1'b0;
    advance    = 1'b0;
  endtask

  task automatic modelLoad();
    expP = '{40, 30, 20};
    expE = '{35, 25, 15};
    expCur = 0;
    expOpp = 0;
  endtask

  task automatic checkHp(input string tag);
    checks++;
    assert (player_hp === packHp(expP[0], expP[1], expP[2]) && enemy_hp === packHp(expE[0], expE[1], expE[2]))
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h/%0h expected=%0h/%0h", tag, player_hp, enemy_hp,
             packHp(expP[0], expP[1], expP[2]), packHp(expE[0], expE[1], expE[2]));
    end
  endtask

  task automatic serviceReq(input int dmg);
    int waitCount = 0;
    logic expPlayer;
    while (calc_req !== 1'b1 && waitCount < 50) begin
      @(negedge Clk);
      waitCount++;
    end
    checkOutput("calc_req_seen", 32'(calc_req), 32'd1);
    if (calc_req === 1'b1) begin
      checkOutput("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      expPlayer = (sb.size() > 0) ? sb.pop_front() : 1'b0;
      checkOutput("calc_is_player", 32'(calc_is_player), 32'(expPlayer));
      checkOutput("busy_req", 32'(busy), 32'd1);
      if (expPlayer) expE[expOpp] = satSub(expE[expOpp], dmg);
      else           expP[expCur] = satSub(expP[expCur], dmg);
      calc_ack    = 1'b1;
      calc_damage = 8'(dmg);
      @(negedge Clk);
      calc_ack    = 1'b0;
      calc_damage = '0;
      checkOutput("calc_req_drop", 32'(calc_req), 32'd0);
      checkOutput("msg_phase", 32'(phase), expPlayer ? 32'd1 : 32'd2);
      checkHp("hp_after_ack");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    Reset = 1'b1; load = 1'b0; start_turn = 1'b0; advance = 1'b0;
    calc_ack = 1'b0; calc_damage = '0;
    player_maxhp = packHp(40, 30, 20);
    enemy_maxhp  = packHp(35, 25, 15);
    player_speed = 8'd50; enemy_speed = 8'd40;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    checkOutput("reset_php", 32'(player_hp), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_phase", 32'(phase), 32'd0);
    checkOutput("reset_req", 32'(calc_req), 32'd0);

    // Test 1: normal turn, player faster.
    applyStimulus(1'b1, 1'b0, 1'b0);
    modelLoad();
    checkHp("load_hp");
    checkOutput("load_cur", 32'(cur_mon), 32'd0);
    sb.push_back(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("req_latency", 32'(calc_req), 32'd1);
    serviceReq(10);
    checkOutput("t1_enemy0", 32'(enemy_hp[7:0]), 32'd25);
    sb.push_back(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    serviceReq(12);
    checkOutput("t1_player0", 32'(player_hp[7:0]), 32'd28);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1_turn_done", 32'(turn_done), 32'd1);
    @(negedge Clk);
    checkOutput("t1_turn_done_low", 32'(turn_done), 32'd0);
    checkOutput("t1_phase_idle", 32'(phase), 32'd0);
    checkOutput("t1_busy_idle", 32'(busy), 32'd0);

    // Test 2: speed tie goes to enemy; zero damage leaves HP unchanged.
    player_speed = 8'd30; enemy_speed = 8'd30;
    sb.push_back(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    serviceReq(0);
    sb.push_back(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    serviceReq(0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t2_turn_done", 32'(turn_done), 32'd1);
    @(negedge Clk);
    checkHp("t2_hp");

    // Test 3: saturating KO; fainted mon does not attack; enemy switches.
    applyStimulus(1'b1, 1'b0, 1'b0);
    modelLoad();
    player_speed = 8'd50; enemy_speed = 8'd40;
    sb.push_back(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    serviceReq(200);
    checkOutput("t3_sat", 32'(enemy_hp[7:0]), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t3_no_req2", 32'(calc_req), 32'd0);
    checkOutput("t3_turn_done", 32'(turn_done), 32'd1);
    @(negedge Clk);
    expOpp = 1;
    checkOutput("t3_opp", 32'(opp_mon), 32'(expOpp));
    checkOutput("t3_cur", 32'(cur_mon), 32'(expCur));

    // Test 4: drive enemy to {0,0,5} at opp_mon 2, then finish it.
    sb.push_back(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    serviceReq(25);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge Clk);
    expOpp = 2;
    checkOutput("t4_opp2", 32'(opp_mon), 32'(expOpp));
    sb.push_back(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    serviceReq(10);
    sb.push_back(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    serviceReq(0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge Clk);
    checkHp("t4_hp_005");
    sb.push_back(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    serviceReq(5);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t4_no_turn_done", 32'(turn_done), 32'd0);
    @(negedge Clk);
    checkOutput("t4_over", 32'(battle_over), 32'd1);
    checkOutput("t4_result", 32'(result), 32'd1);
    checkOutput("t4_phase_win", 32'(phase), 32'd3);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t4_start_ign", 32'(calc_req), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t4_still_over", 32'(battle_over), 32'd1);
    checkHp("t4_hp_held");
    applyStimulus(1'b1, 1'b0, 1'b0);
    modelLoad();
    checkOutput("t4_load_clear", 32'(battle_over), 32'd0);
    checkOutput("t4_load_phase", 32'(phase), 32'd0);
    checkOutput("t4_load_opp", 32'(opp_mon), 32'd0);

    // Test 5: stalled calculator, then reset with a pending ack.
    player_speed = 8'd10; enemy_speed = 8'd20;
    sb.push_back(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge Clk);
    checkOutput("t5_req_held", 32'(calc_req), 32'd1);
    checkOutput("t5_is_player", 32'(calc_is_player), 32'(sb.pop_front()));
    checkHp("t5_hp_unchanged");
    Reset = 1'b1; calc_ack = 1'b1; calc_damage = 8'd5;
    @(negedge Clk);
    Reset = 1'b0; calc_ack = 1'b0; calc_damage = '0;
    checkOutput("t5_rst_req", 32'(calc_req), 32'd0);
    checkOutput("t5_rst_isp", 32'(calc_is_player), 32'd0);
    checkOutput("t5_rst_php", 32'(player_hp), 32'd0);
    checkOutput("t5_rst_ehp", 32'(enemy_hp), 32'd0);
    checkOutput("t5_rst_idx", 32'({cur_mon, opp_mon}), 32'd0);
    checkOutput("t5_rst_flags", 32'({busy, turn_done, battle_over, result}), 32'd0);
    checkOutput("t5_rst_phase", 32'(phase), 32'd0);

    // Test 6: load wins over start_turn in the same cycle.
    player_speed = 8'd50; enemy_speed = 8'd40;
    applyStimulus(1'b1, 1'b1, 1'b0);
    modelLoad();
    checkHp("t6_hp");
    checkOutput("t6_no_req", 32'(calc_req), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    @(negedge Clk);
    checkOutput("t6_no_req_later", 32'(calc_req), 32'd0);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
